// File: rtl/dm_ctrl.sv
// Purpose : byte-wide data-memory responder for the accumulator path; byte writes, fixed-latency reads.
// Latency : writes land on the accepting edge; dm_rdy pulses RD_LAT cycles after the read request cycle.
// Backpress: no queueing; any request while a read is in flight is dropped and flagged on err.
//
// Ports:
//   clock, rst        posedge clock, asynchronous active-high reset
//   dm_wr, dm_r       single-cycle write / read request strobes
//   addr, dm_in       byte address (sampled at acceptance), write data
//   dm_out, dm_rdy    read data (held until next read completes), one-cycle data-valid pulse
//   busy, err         read in flight, one-cycle pulse on a rejected or colliding request
//   inc               (DM_AUTOINC_EN only) use and advance the internal address pointer
//
// Optional feature macro: DM_AUTOINC_EN (auto-incrementing address pointer and inc port).
module dm_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              dm_wr,
  input  logic              dm_r,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        dm_in,
`ifdef DM_AUTOINC_EN
  input  logic              inc,
`endif
  output logic [7:0]        dm_out,
  output logic              dm_rdy,
  output logic              busy,
  output logic              err
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  logic [7:0] mem [2**ADDR_W];

`ifdef DM_AUTOINC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  assign acc_addr = inc ? ptr_q : addr;
`else
  assign acc_addr = addr;
`endif

  // In IDLE only the single-cycle read path consumes data, straight from the
  // request address; in RD_WAIT the address latched at acceptance is used.
  always_comb begin
    rd_addr = addr_q;
    if (state_q == IDLE) begin
      rd_addr = acc_addr;
    end
  end

  assign rd_data = mem[rd_addr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
`ifdef DM_AUTOINC_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (dm_wr) begin
          // A simultaneous read is dropped; the write still goes through.
          mem_we = 1'b1;
          err_d  = dm_r;
`ifdef DM_AUTOINC_EN
          ptr_d  = acc_addr + ADDR_W'(1);
`endif
        end else if (dm_r) begin
`ifdef DM_AUTOINC_EN
          ptr_d  = acc_addr + ADDR_W'(1);
`endif
          if (RD_LAT == 1) begin
            dout_d = rd_data;
            rdy_d  = 1'b1;
          end else begin
            addr_d  = acc_addr;
            cnt_d   = 4'(RD_LAT - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Requests arriving while busy are ignored but flagged.
        err_d = dm_wr | dm_r;
        // cnt_q counts the edges left in RD_WAIT; the read completes on the
        // edge whose decrement brings it to zero, giving RD_LAT total cycles.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          dout_d  = rd_data;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      dout_q  <= 8'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DM_AUTOINC_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
`ifdef DM_AUTOINC_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[acc_addr] <= dm_in;
    end
  end

  assign dm_out = dout_q;
  assign dm_rdy = rdy_q;
  assign err    = err_q;
  assign busy   = (state_q == RD_WAIT);

endmodule
